mcu_local_axil_wr_fsm: RTL and testbench

Write-back stage directly downstream of the MCU local AXI-Lite read stage and its compute datapath. It consumes an AXI-Stream of DATA_WIDTH result words and writes them to consecutive addresses through an AXI-Lite write master. Sequencing follows the MCU global FSM. The block reports done and error back to the global FSM. Only one write transaction is outstanding at any time.

---
 rtl/mcu_local_axil_wr_fsm_pkg.sv | 34 +++
 rtl/mcu_axil_wr_channel.sv | 51 +++++
 rtl/mcu_local_axil_wr_fsm.sv | 188 ++++++++++++++++++
 tb/tb_mcu_local_axil_wr_fsm.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcu_local_axil_wr_fsm_pkg.sv
// Shared definitions for the MCU local AXI-Lite write-back stage.
// Holds the global FSM encodings (common with the read stage), the AXI
// response codes and the local write-FSM state encodings.
package mcu_local_axil_wr_fsm_pkg;

    localparam int GLO_FSM_WIDTH = 2;

    localparam logic [1:0] GLO_FSM_STR = 2'd0;
    localparam logic [1:0] GLO_FSM_OPE = 2'd1;
    localparam logic [1:0] GLO_FSM_ERR = 2'd2;
    localparam logic [1:0] GLO_FSM_END = 2'd3;

    typedef logic [1:0] axi_resp_t;

    localparam axi_resp_t AXI_RESP_OKAY   = 2'b00;
    localparam axi_resp_t AXI_RESP_EXOKAY = 2'b01;
    localparam axi_resp_t AXI_RESP_SLVERR = 2'b10;
    localparam axi_resp_t AXI_RESP_DECERR = 2'b11;

    localparam int WR_STATE_WIDTH = 3;

    localparam logic [2:0] WR_STR  = 3'd0;
    localparam logic [2:0] WR_OPE  = 3'd1;
    localparam logic [2:0] WR_AW_W = 3'd2;
    localparam logic [2:0] WR_WB   = 3'd3;
    localparam logic [2:0] WR_END  = 3'd4;
    localparam logic [2:0] WR_ERR  = 3'd5;

    // Only OKAY counts as success; EXOKAY is meaningless for a plain write.
    function automatic logic resp_is_okay(input axi_resp_t resp);
        return resp == AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/mcu_axil_wr_channel.sv
// AW+W pair tracker for a single AXI-Lite write.
// A start strobe raises awvalid and wvalid together; each drops on its own
// handshake, and both_done fires in the cycle the last outstanding one
// completes (either order, or both in the same cycle).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               launch a new AW+W pair (ignored while one is open)
//   awready, wready     slave readies
//   awvalid, wvalid     master valids
//   both_done           strobe: the pair fully completes this cycle
module mcu_axil_wr_channel (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic awready,
    input  logic wready,
    output logic awvalid,
    output logic wvalid,
    output logic both_done
);
    import mcu_local_axil_wr_fsm_pkg::*;

    logic aw_clear;
    logic w_clear;
    logic busy;

    // A channel counts as clear if it already finished or finishes now.
    assign aw_clear  = !awvalid || awready;
    assign w_clear   = !wvalid || wready;
    assign busy      = awvalid || wvalid;
    assign both_done = busy && aw_clear && w_clear;

    always_ff @(posedge clk) begin
        if (rst) begin
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
        end else if (start && !busy) begin
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
        end else begin
            if (awvalid && awready) begin
                awvalid <= 1'b0;
            end
            if (wvalid && wready) begin
                wvalid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mcu_local_axil_wr_fsm.sv
// MCU local AXI-Lite write-back stage.
// Consumes an AXI-Stream of result words and writes each one to consecutive
// addresses starting at base_addr, one AXI-Lite write outstanding at a time.
// Reports done (pulse) / error (level) to the global FSM.
//
// Build option: MCU_WR_TLAST_CHECK_EN -- when defined, a beat whose tlast
// disagrees with the word counter sends the block to ERR without writing.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   s_axis_*                 result word stream (tdata/tvalid/tready/tlast)
//   m_axil_aw*/w*/b*         AXI-Lite write master (no AR/R)
//   glo_fsm_state            global FSM state
//   base_addr                byte address of word 0
//   word_count_max           number of words in the job
//   done                     one-cycle pulse on final OKAY response
//   error                    high while in ERR
//
// state   | meaning
// --------+-----------------------------------------------------------
// STR     | idle, waiting for global STR to start a job
// OPE     | accepting the next AXIS word
// AW_W    | AW and W of the current word in flight
// WB      | waiting for the write response
// END     | job complete, waiting for global END
// ERR     | failure, waiting for global ERR; stray B still accepted
module mcu_local_axil_wr_fsm #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDR_WIDTH    = 32,
    parameter int CNT_WIDTH     = 32,
    parameter int GLO_FSM_WIDTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    input  logic                      s_axis_tlast,
    output logic [ADDR_WIDTH-1:0]     m_axil_awaddr,
    output logic [2:0]                m_axil_awprot,
    output logic                      m_axil_awvalid,
    input  logic                      m_axil_awready,
    output logic [DATA_WIDTH-1:0]     m_axil_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_axil_wstrb,
    output logic                      m_axil_wvalid,
    input  logic                      m_axil_wready,
    input  logic [1:0]                m_axil_bresp,
    input  logic                      m_axil_bvalid,
    output logic                      m_axil_bready,
    input  logic [GLO_FSM_WIDTH-1:0]  glo_fsm_state,
    input  logic [ADDR_WIDTH-1:0]     base_addr,
    input  logic [CNT_WIDTH-1:0]      word_count_max,
    output logic                      done,
    output logic                      error
);
    import mcu_local_axil_wr_fsm_pkg::*;

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(STRB_WIDTH);
    localparam logic [CNT_WIDTH:0]    CNT_ONE_EXT = (CNT_WIDTH+1)'(1);

    logic [WR_STATE_WIDTH-1:0] state;
    logic [ADDR_WIDTH-1:0]     addr_reg;
    logic [DATA_WIDTH-1:0]     wdata_reg;
    logic [CNT_WIDTH-1:0]      cnt;
    logic                      done_reg;

    logic glo_str;
    logic glo_end;
    logic glo_err;
    logic beat;
    logic is_final;
    logic tlast_bad;
    logic start_wr;
    logic both_done;
    logic b_ok;

    assign glo_str = glo_fsm_state == GLO_FSM_WIDTH'(GLO_FSM_STR);
    assign glo_end = glo_fsm_state == GLO_FSM_WIDTH'(GLO_FSM_END);
    assign glo_err = glo_fsm_state == GLO_FSM_WIDTH'(GLO_FSM_ERR);

    // One extra bit so cnt+1 never wraps into a false match.
    assign is_final = ({1'b0, cnt} + CNT_ONE_EXT) == {1'b0, word_count_max};

`ifdef MCU_WR_TLAST_CHECK_EN
    assign tlast_bad = s_axis_tlast != is_final;
`else
    logic unused_tlast;
    assign unused_tlast = s_axis_tlast;
    assign tlast_bad    = 1'b0;
`endif

    assign s_axis_tready = state == WR_OPE;
    assign beat          = s_axis_tready && s_axis_tvalid;
    assign start_wr      = beat && !tlast_bad;
    assign b_ok          = resp_is_okay(m_axil_bresp);

    assign m_axil_awaddr = addr_reg;
    assign m_axil_awprot = 3'b000;
    assign m_axil_wdata  = wdata_reg;
    assign m_axil_wstrb  = '1;
    // ERR keeps bready up so a response still owed by the slave is drained.
    assign m_axil_bready = (state == WR_WB) || (state == WR_ERR);

    assign done  = done_reg;
    assign error = state == WR_ERR;

    mcu_axil_wr_channel u_channel (
        .clk       (clk),
        .rst       (rst),
        .start     (start_wr),
        .awready   (m_axil_awready),
        .wready    (m_axil_wready),
        .awvalid   (m_axil_awvalid),
        .wvalid    (m_axil_wvalid),
        .both_done (both_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= WR_STR;
            addr_reg  <= '0;
            wdata_reg <= '0;
            cnt       <= '0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state)
                WR_STR: begin
                    if (glo_str) begin
                        if (word_count_max == '0) begin
                            state <= WR_ERR;
                        end else begin
                            addr_reg <= base_addr;
                            cnt      <= '0;
                            state    <= WR_OPE;
                        end
                    end
                end
                WR_OPE: begin
                    if (beat) begin
                        if (tlast_bad) begin
                            state <= WR_ERR;
                        end else begin
                            wdata_reg <= s_axis_tdata;
                            state     <= WR_AW_W;
                        end
                    end
                end
                WR_AW_W: begin
                    if (both_done) begin
                        state <= WR_WB;
                    end
                end
                WR_WB: begin
                    if (m_axil_bvalid) begin
                        if (!b_ok) begin
                            state <= WR_ERR;
                        end else begin
                            cnt      <= cnt + CNT_WIDTH'(1);
                            addr_reg <= addr_reg + ADDR_STEP;
                            if (is_final) begin
                                state    <= WR_END;
                                done_reg <= 1'b1;
                            end else begin
                                state <= WR_OPE;
                            end
                        end
                    end
                end
                WR_END: begin
                    if (glo_end) begin
                        state <= WR_STR;
                    end
                end
                WR_ERR: begin
                    if (glo_err) begin
                        state <= WR_STR;
                    end
                end
                default: begin
                    state <= WR_STR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mcu_local_axil_wr_fsm.sv
// Testbench for mcu_local_axil_wr_fsm: directed jobs plus randomized jobs
// against a responsive AXI-Lite slave model; expected writes derived from
// base address, word index and the stream data.
`timescale 1ns/1ps
module tb_mcu_local_axil_wr_fsm;
    import mcu_local_axil_wr_fsm_pkg::*;

    localparam int DW = 16;
    localparam int AW = 32;
    localparam int CW = 32;
    localparam int GW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          s_axis_tlast;
    logic [AW-1:0] m_axil_awaddr;
    logic [2:0]    m_axil_awprot;
    logic          m_axil_awvalid;
    logic          m_axil_awready;
    logic [DW-1:0] m_axil_wdata;
    logic [DW/8-1:0] m_axil_wstrb;
    logic          m_axil_wvalid;
    logic          m_axil_wready;
    logic [1:0]    m_axil_bresp;
    logic          m_axil_bvalid;
    logic          m_axil_bready;
    logic [GW-1:0] glo_fsm_state;
    logic [AW-1:0] base_addr;
    logic [CW-1:0] word_count_max;
    logic          done;
    logic          error;

    always #5 clk = ~clk;

    mcu_local_axil_wr_fsm #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW), .GLO_FSM_WIDTH(GW)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
        .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
        .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
        .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
        .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid),
        .m_axil_bready(m_axil_bready),
        .glo_fsm_state(glo_fsm_state), .base_addr(base_addr),
        .word_count_max(word_count_max), .done(done), .error(error)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- slave model ----------------
    logic [AW-1:0] aw_q[$];
    logic [DW-1:0] w_q[$];
    int   b_iss, b_n;
    int   err_idx = -1;
    logic [1:0] err_resp = 2'b10;
    bit   slv_rand = 0;
    int   aw_dly_cfg = 0, w_dly_cfg = 0, b_dly_cfg = 0;
    int   aw_dly = 0, w_dly = 0, b_dly = 0;
    int   aw_age = 0, w_age = 0, b_age = 0;
    bit   b_hs = 0, aw_taken = 0, w_taken = 0, prev_awv = 0, prev_wv = 0;
    logic [AW-1:0] prev_awaddr;
    logic [DW-1:0] prev_wdata;
    int   stab_viol = 0, aw_extra = 0, w_extra = 0;

    function automatic int pick(input int cfg);
        if (slv_rand) return int'($urandom_range(0, cfg));
        return cfg;
    endfunction

    initial begin
        m_axil_awready = 1'b0;
        m_axil_wready  = 1'b0;
        m_axil_bvalid  = 1'b0;
        m_axil_bresp   = 2'b00;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_axil_awready = 1'b0;
                m_axil_wready  = 1'b0;
                m_axil_bvalid  = 1'b0;
                b_hs = 0; aw_taken = 0; w_taken = 0; prev_awv = 0; prev_wv = 0;
                aw_age = 0; w_age = 0; b_age = 0;
            end else begin
                if (prev_awv && m_axil_awvalid && m_axil_awaddr !== prev_awaddr) stab_viol++;
                if (prev_wv && m_axil_wvalid && m_axil_wdata !== prev_wdata) stab_viol++;
                if (aw_taken && m_axil_awvalid) aw_extra++;
                if (w_taken && m_axil_wvalid) w_extra++;
                if (aw_taken && w_taken) begin
                    aw_taken = 0;
                    w_taken  = 0;
                end
                if (b_hs) begin
                    m_axil_bvalid = 1'b0;
                    b_n++;
                    b_hs  = 0;
                    b_age = 0;
                    b_dly = pick(b_dly_cfg);
                end
                if (!m_axil_bvalid &&
                    ((aw_q.size() < w_q.size()) ? aw_q.size() : w_q.size()) > b_iss) begin
                    if (b_age >= b_dly) begin
                        m_axil_bvalid = 1'b1;
                        m_axil_bresp  = (b_iss == err_idx) ? err_resp : 2'b00;
                        b_iss++;
                    end else begin
                        b_age++;
                    end
                end
                b_hs = m_axil_bvalid && m_axil_bready;
                m_axil_awready = m_axil_awvalid && (aw_age >= aw_dly);
                m_axil_wready  = m_axil_wvalid && (w_age >= w_dly);
                if (m_axil_awvalid && !m_axil_awready) aw_age++;
                if (m_axil_wvalid && !m_axil_wready) w_age++;
                if (m_axil_awvalid && m_axil_awready) begin
                    aw_q.push_back(m_axil_awaddr);
                    aw_taken = 1; aw_age = 0; aw_dly = pick(aw_dly_cfg);
                end
                if (m_axil_wvalid && m_axil_wready) begin
                    w_q.push_back(m_axil_wdata);
                    w_taken = 1; w_age = 0; w_dly = pick(w_dly_cfg);
                end
                prev_awv = m_axil_awvalid && !m_axil_awready;
                prev_wv  = m_axil_wvalid && !m_axil_wready;
                prev_awaddr = m_axil_awaddr;
                prev_wdata  = m_axil_wdata;
            end
        end
    end

    // ---------------- job driver / reference ----------------
    logic [DW-1:0] jd[$];
    bit   jl[$];
    logic [AW-1:0] job_base;
    int   done_cnt;
    bit   err_seen;

    task automatic make_job(input int n, input int tlast_idx);
        jd.delete();
        jl.delete();
        for (int i = 0; i < n; i++) begin
            jd.push_back(DW'($urandom));
            jl.push_back(i == tlast_idx);
        end
    endtask

    task automatic run_job(input logic [AW-1:0] base, input int n, input int gap_pct);
        int idx, cyc, budget;
        bit hs, finished;
        aw_q.delete(); w_q.delete();
        b_iss = 0; b_n = 0; done_cnt = 0; err_seen = 0;
        stab_viol = 0; aw_extra = 0; w_extra = 0;
        aw_dly = pick(aw_dly_cfg); w_dly = pick(w_dly_cfg); b_dly = pick(b_dly_cfg);
        job_base = base;
        base_addr = base;
        word_count_max = CW'(n);
        glo_fsm_state = GLO_FSM_STR;
        @(negedge clk);
        glo_fsm_state = GLO_FSM_OPE;
        idx = 0; cyc = 0; hs = 0; finished = 0;
        budget = n * 40 + 50;
        while (!finished && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (hs) idx++;
            if (done) done_cnt++;
            if (error) err_seen = 1;
            if (done || error) finished = 1;
            s_axis_tvalid = 1'b0;
            if (idx < jd.size()) begin
                s_axis_tdata  = jd[idx];
                s_axis_tlast  = jl[idx];
                s_axis_tvalid = !finished && (int'($urandom_range(0, 99)) >= gap_pct);
            end
            hs = s_axis_tvalid && s_axis_tready;
        end
        chk("job_bounded", finished, 1);
        s_axis_tvalid = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
    endtask

    task automatic check_job(input string tag, input int exp_wr, input int exp_done, input bit exp_err);
        chk({tag, "_aw_count"}, aw_q.size(), exp_wr);
        chk({tag, "_w_count"}, w_q.size(), exp_wr);
        chk({tag, "_b_count"}, b_n, exp_wr);
        for (int i = 0; i < exp_wr && i < aw_q.size() && i < w_q.size(); i++) begin
            chk($sformatf("%s_addr%0d", tag, i), aw_q[i], AW'(job_base + AW'(i * (DW / 8))));
            chk($sformatf("%s_data%0d", tag, i), w_q[i], jd[i]);
        end
        chk({tag, "_done_pulses"}, done_cnt, exp_done);
        chk({tag, "_error"}, error, exp_err);
        chk({tag, "_tready_idle"}, s_axis_tready, 0);
        chk({tag, "_stable"}, stab_viol, 0);
        chk({tag, "_valid_drop"}, aw_extra + w_extra, 0);
    endtask

    task automatic close_job(input string tag, input bit was_err);
        glo_fsm_state = was_err ? GLO_FSM_ERR : GLO_FSM_END;
        repeat (2) @(negedge clk);
        chk({tag, "_after_close_error"}, error, 0);
        glo_fsm_state = GLO_FSM_OPE;
        @(negedge clk);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, e, cyc;
        rst = 1'b1;
        s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        glo_fsm_state = GLO_FSM_OPE;
        base_addr = '0; word_count_max = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("rst_tready", s_axis_tready, 0);
        chk("rst_awvalid", m_axil_awvalid, 0);
        chk("rst_wvalid", m_axil_wvalid, 0);
        chk("rst_bready", m_axil_bready, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_awprot", m_axil_awprot, 3'b000);
        chk("rst_wstrb", m_axil_wstrb, 2'b11);
        chk("rst_awaddr", m_axil_awaddr, 0);

        // basic 4-word job, zero-wait slave
        make_job(4, 3);
        run_job(32'h1000, 4, 0);
        check_job("basic", 4, 1, 0);
        close_job("basic", 0);

        // W accepted 3 cycles before AW
        aw_dly_cfg = 3;
        make_job(1, 0);
        run_job(32'h0000_4000, 1, 0);
        check_job("w_first", 1, 1, 0);
        close_job("w_first", 0);
        aw_dly_cfg = 0;

        // error response on word 2 of 4
        err_idx = 1; err_resp = 2'b10;
        make_job(4, 3);
        run_job(32'h1000, 4, 0);
        check_job("bresp_err", 2, 0, 1);
        close_job("bresp_err", 1);
        err_idx = -1;

        // zero-length job
        aw_q.delete(); w_q.delete();
        base_addr = 32'h5000; word_count_max = '0;
        glo_fsm_state = GLO_FSM_STR;
        @(negedge clk);
        glo_fsm_state = GLO_FSM_OPE;
        chk("zero_len_error", error, 1);
        chk("zero_len_tready", s_axis_tready, 0);
        repeat (4) @(negedge clk);
        chk("zero_len_no_aw", aw_q.size(), 0);
        chk("zero_len_no_w", w_q.size(), 0);
        close_job("zero_len", 1);

        // tlast on word 2 of 4
        make_job(4, 1);
        run_job(32'h0000_6000, 4, 0);
`ifdef MCU_WR_TLAST_CHECK_EN
        check_job("tlast_early", 1, 0, 1);
        close_job("tlast_early", 1);
        make_job(2, -1);
        run_job(32'h0000_6100, 2, 0);
        check_job("tlast_missing", 1, 0, 1);
        close_job("tlast_missing", 1);
`else
        check_job("tlast_ignored", 4, 1, 0);
        close_job("tlast_ignored", 0);
`endif

        // reset in AW_W
        aw_dly_cfg = 10; w_dly_cfg = 10;
        aw_dly = 10; w_dly = 10;
        aw_q.delete(); w_q.delete();
        base_addr = 32'h3000; word_count_max = 32'd4;
        glo_fsm_state = GLO_FSM_STR;
        @(negedge clk);
        glo_fsm_state = GLO_FSM_OPE;
        s_axis_tdata = 16'hBEEF; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b1;
        cyc = 0;
        while (!m_axil_awvalid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("rst_mid_reached_aw_w", m_axil_awvalid, 1);
        s_axis_tvalid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_awvalid", m_axil_awvalid, 0);
        chk("rst_mid_wvalid", m_axil_wvalid, 0);
        chk("rst_mid_tready", s_axis_tready, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_no_aw", aw_q.size(), 0);
        aw_dly_cfg = 0; w_dly_cfg = 0;
        make_job(2, 1);
        run_job(32'h2000, 2, 0);
        check_job("after_rst", 2, 1, 0);
        close_job("after_rst", 0);

        // randomized jobs
        slv_rand = 1; aw_dly_cfg = 3; w_dly_cfg = 3; b_dly_cfg = 3;
        for (int j = 0; j < 12; j++) begin
            logic [AW-1:0] b;
            n = int'($urandom_range(1, 6));
            b = (j == 5) ? 32'hFFFF_FFFC : {$urandom, 1'b0};
            if (j == 5) n = 4;
            e = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n - 1)) : -1;
            err_idx  = e;
            err_resp = 2'($urandom_range(1, 3));
            make_job(n, n - 1);
            run_job(b, n, 30);
            check_job($sformatf("rand%0d", j), (e >= 0) ? e + 1 : n, (e >= 0) ? 0 : 1, e >= 0);
            close_job($sformatf("rand%0d", j), e >= 0);
        end
        err_idx = -1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
